// File: rtl/dbf_beam_combine_if.sv
// Purpose : sample/weight input beats and beam output bundle for the DBF beam combiner.
// Ports   : in_valid/in_sof qualify one channel beat of x_re/x_im (sample) and w_re/w_im (Q1.15 weight);
//           out_valid pulses with out_re/out_im/sat per frame, frame_err pulses on a framing violation.
// Modports: master = beat producer / beam consumer, slave = combiner.
interface dbf_beam_combine_if;
    logic               in_valid;
    logic               in_sof;
    logic signed [15:0] x_re;
    logic signed [15:0] x_im;
    logic signed [15:0] w_re;
    logic signed [15:0] w_im;
    logic               out_valid;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic               sat;
    logic               frame_err;

    modport master (
        output in_valid, in_sof, x_re, x_im, w_re, w_im,
        input  out_valid, out_re, out_im, sat, frame_err
    );

    modport slave (
        input  in_valid, in_sof, x_re, x_im, w_re, w_im,
        output out_valid, out_re, out_im, sat, frame_err
    );
endinterface

// File: rtl/dbf_beam_combine.sv
// Purpose : per-channel complex multiply of sample x weight, coherent sum over NUM_CH channels,
//           then round-half-up, >>> OUT_SHIFT and saturate to 16 bits -> one beam sample per frame.
// Latency : last-channel beat sampled at edge n -> out_valid during the cycle after edge n+4.
// Backpressure: none; one beat per clock accepted, consumer must take every out_valid.
// Ports   : clk, rst (async, active-high); bus (slave modport of dbf_beam_combine_if).
module dbf_beam_combine #(
    parameter int NUM_CH    = 8,
    parameter int OUT_SHIFT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    dbf_beam_combine_if.slave    bus
);
    localparam int CW = $clog2(NUM_CH);
    localparam int AW = 33 + $clog2(NUM_CH);
    // One spare bit so adding the rounding constant can never overflow.
    localparam int RW = AW + 1;
    localparam logic signed [RW-1:0] RND  = {{(RW-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    localparam logic signed [RW-1:0] MAXV = 32767;
    localparam logic signed [RW-1:0] MINV = -32768;

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_ch_cnt, w_ch_cnt_nxt;
    logic           w_take, w_first, w_last, w_err;
    logic           w_at_last;

    assign w_at_last = (r_ch_cnt == CW'(NUM_CH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ch_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ch_cnt <= w_ch_cnt_nxt;
        end
    end

    // Next-state logic; bubbles (in_valid=0) hold everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_ch_cnt_nxt = r_ch_cnt;
        if (bus.in_valid) begin
            case (r_state)
                IDLE: begin
                    if (bus.in_sof) begin
                        w_state_nxt  = ACCUM;
                        w_ch_cnt_nxt = CW'(1);
                    end
                end
                default: begin
                    // The last channel wins over a coincident sof: frame closes normally.
                    if (w_at_last) begin
                        w_state_nxt  = IDLE;
                        w_ch_cnt_nxt = '0;
                    end else if (bus.in_sof) begin
                        w_ch_cnt_nxt = CW'(1);
                    end else begin
                        w_ch_cnt_nxt = r_ch_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Beat classification. A mid-frame sof restarts as channel 0; the partial sum
    // is discarded because the restart beat reloads the accumulator.
    always_comb begin
        w_take  = 1'b0;
        w_first = 1'b0;
        w_last  = 1'b0;
        w_err   = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                IDLE: begin
                    if (bus.in_sof) begin
                        w_take  = 1'b1;
                        w_first = 1'b1;
                    end else begin
                        w_err   = 1'b1;
                    end
                end
                default: begin
                    w_take = 1'b1;
                    if (w_at_last) begin
                        w_last = 1'b1;
                    end else if (bus.in_sof) begin
                        w_first = 1'b1;
                        w_err   = 1'b1;
                    end
                end
            endcase
        end
    end

    // S1: input register
    logic               r_s1_vld, r_s1_first, r_s1_last, r_frame_err;
    logic signed [15:0] r_s1_xr, r_s1_xi, r_s1_wr, r_s1_wi;
    // S2: partial products
    logic               r_s2_vld, r_s2_first, r_s2_last;
    logic signed [31:0] r_s2_rr, r_s2_ii, r_s2_ri, r_s2_ir;
    // S3: complex product
    logic               r_s3_vld, r_s3_first, r_s3_last;
    logic signed [32:0] r_s3_pre, r_s3_pim;
    // S4: accumulator
    logic               r_s4_done;
    logic signed [AW-1:0] r_acc_re, r_acc_im;
    // S5: output register
    logic               r_out_vld, r_sat;
    logic signed [15:0] r_out_re, r_out_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0; r_s1_first <= 1'b0; r_s1_last <= 1'b0; r_frame_err <= 1'b0;
            r_s1_xr  <= '0;   r_s1_xi    <= '0;   r_s1_wr   <= '0;   r_s1_wi     <= '0;
            r_s2_vld <= 1'b0; r_s2_first <= 1'b0; r_s2_last <= 1'b0;
            r_s2_rr  <= '0;   r_s2_ii    <= '0;   r_s2_ri   <= '0;   r_s2_ir     <= '0;
            r_s3_vld <= 1'b0; r_s3_first <= 1'b0; r_s3_last <= 1'b0;
            r_s3_pre <= '0;   r_s3_pim   <= '0;
            r_s4_done <= 1'b0;
            r_acc_re <= '0;   r_acc_im   <= '0;
        end else begin
            r_frame_err <= w_err;
            r_s1_vld    <= w_take;
            r_s1_first  <= w_first;
            r_s1_last   <= w_last;
            if (w_take) begin
                r_s1_xr <= bus.x_re;
                r_s1_xi <= bus.x_im;
                r_s1_wr <= bus.w_re;
                r_s1_wi <= bus.w_im;
            end

            r_s2_vld   <= r_s1_vld;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            if (r_s1_vld) begin
                r_s2_rr <= r_s1_xr * r_s1_wr;
                r_s2_ii <= r_s1_xi * r_s1_wi;
                r_s2_ri <= r_s1_xr * r_s1_wi;
                r_s2_ir <= r_s1_xi * r_s1_wr;
            end

            r_s3_vld   <= r_s2_vld;
            r_s3_first <= r_s2_first;
            r_s3_last  <= r_s2_last;
            if (r_s2_vld) begin
                r_s3_pre <= 33'(r_s2_rr) - 33'(r_s2_ii);
                r_s3_pim <= 33'(r_s2_ri) + 33'(r_s2_ir);
            end

            // S5 samples r_acc_* at the same edge a new frame's first beat reloads it,
            // so back-to-back frames do not interfere.
            r_s4_done <= r_s3_vld & r_s3_last;
            if (r_s3_vld) begin
                if (r_s3_first) begin
                    r_acc_re <= AW'(r_s3_pre);
                    r_acc_im <= AW'(r_s3_pim);
                end else begin
                    r_acc_re <= r_acc_re + AW'(r_s3_pre);
                    r_acc_im <= r_acc_im + AW'(r_s3_pim);
                end
            end
        end
    end

    // Round half up, arithmetic shift, clamp
    logic signed [RW-1:0] w_rnd_re, w_rnd_im, w_sh_re, w_sh_im;
    logic                 w_hi_re, w_lo_re, w_hi_im, w_lo_im;
    logic signed [15:0]   w_y_re, w_y_im;

    always_comb begin
        w_rnd_re = RW'(r_acc_re) + RND;
        w_rnd_im = RW'(r_acc_im) + RND;
        w_sh_re  = w_rnd_re >>> OUT_SHIFT;
        w_sh_im  = w_rnd_im >>> OUT_SHIFT;
        w_hi_re  = (w_sh_re > MAXV);
        w_lo_re  = (w_sh_re < MINV);
        w_hi_im  = (w_sh_im > MAXV);
        w_lo_im  = (w_sh_im < MINV);
        w_y_re   = w_hi_re ? 16'sh7FFF : (w_lo_re ? 16'sh8000 : w_sh_re[15:0]);
        w_y_im   = w_hi_im ? 16'sh7FFF : (w_lo_im ? 16'sh8000 : w_sh_im[15:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_sat     <= 1'b0;
            r_out_re  <= '0;
            r_out_im  <= '0;
        end else begin
            r_out_vld <= r_s4_done;
            r_sat     <= r_s4_done & (w_hi_re | w_lo_re | w_hi_im | w_lo_im);
            if (r_s4_done) begin
                r_out_re <= w_y_re;
                r_out_im <= w_y_im;
            end
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.out_re    = r_out_re;
    assign bus.out_im    = r_out_im;
    assign bus.sat       = r_sat;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_dbf_beam_combine.sv
// Bench for dbf_beam_combine: scoreboard of expected beam samples built from a longint
// reference of the complex sum, round, shift and clamp; checks value, sat and latency.
module tb_dbf_beam_combine;
    localparam int NUM_CH    = 8;
    localparam int OUT_SHIFT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    dbf_beam_combine_if ifc();

    dbf_beam_combine #(.NUM_CH(NUM_CH), .OUT_SHIFT(OUT_SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint re;
        longint im;
        longint sat;
        int     cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_ferr = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint clamp16(input longint s, output bit hit);
        longint y;
        y   = (s + (64'sd1 <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
        hit = 1'b0;
        if (y > 32767)  begin y = 32767;  hit = 1'b1; end
        if (y < -32768) begin y = -32768; hit = 1'b1; end
        return y;
    endfunction

    // Output monitor: away from the rising edge
    always @(negedge clk) begin
        exp_t e;
        if (ifc.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_re",  ifc.out_re, e.re);
                chk("out_im",  ifc.out_im, e.im);
                chk("sat",     ifc.sat,    e.sat);
                chk("latency", cyc,        e.cyc);
            end
        end else if (ifc.sat) begin
            chk("sat_without_valid", 1, 0);
        end
        if (ifc.frame_err) n_ferr++;
    end

    // One beat, optionally preceded by random bubbles. Entry/exit at posedge+1.
    task automatic beat(input bit sof, input logic signed [15:0] xr, xi, wr, wi,
                        input int max_bub, output int scyc);
        int nb;
        nb = (max_bub > 0) ? int'($urandom_range(0, max_bub)) : 0;
        ifc.in_valid = 1'b0;
        repeat (nb) begin @(posedge clk); #1; end
        ifc.in_valid = 1'b1;
        ifc.in_sof   = sof;
        ifc.x_re = xr; ifc.x_im = xi; ifc.w_re = wr; ifc.w_im = wi;
        scyc = cyc + 1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        ifc.in_sof   = 1'b0;
    endtask

    // nbeats < NUM_CH models an incomplete frame (no output expected).
    task automatic frame(input int nbeats, input logic signed [15:0] xr, xi, wr, wi,
                         input int max_bub, input bit sof_on_last);
        longint sr, si;
        int     scyc;
        bit     h_re, h_im;
        exp_t   e;
        sr = 0; si = 0; scyc = 0;
        for (int b = 0; b < nbeats; b++) begin
            sr += longint'(xr) * longint'(wr) - longint'(xi) * longint'(wi);
            si += longint'(xr) * longint'(wi) + longint'(xi) * longint'(wr);
            beat((b == 0) || (sof_on_last && b == nbeats - 1), xr, xi, wr, wi, max_bub, scyc);
        end
        if (nbeats == NUM_CH) begin
            e.re  = clamp16(sr, h_re);
            e.im  = clamp16(si, h_im);
            e.sat = longint'(h_re | h_im);
            e.cyc = scyc + 4;
            q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, q.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int base, scyc;
        ifc.in_valid = 1'b0; ifc.in_sof = 1'b0;
        ifc.x_re = '0; ifc.x_im = '0; ifc.w_re = '0; ifc.w_im = '0;
        idle(3);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_re",    ifc.out_re,    0);
        chk("rst_out_im",    ifc.out_im,    0);
        chk("rst_sat",       ifc.sat,       0);
        chk("rst_frame_err", ifc.frame_err, 0);
        rst = 1'b0;
        idle(2);

        // Case 1: real x real
        frame(NUM_CH, 16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        drain("drain_c1");
        // Case 2: imaginary products
        frame(NUM_CH, 16'sd0, 16'sd1000, 16'sd0, 16'sh7FFF, 0, 1'b0);
        frame(NUM_CH, 16'sd1000, 16'sd0, 16'sd0, 16'sh7FFF, 0, 1'b0);
        drain("drain_c2");
        // Case 3: saturation both directions
        frame(NUM_CH, 16'sh7FFF, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        frame(NUM_CH, -16'sd32768, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        drain("drain_c3");
        // Case 4: back-to-back, then with random bubbles
        frame(NUM_CH, 16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        frame(NUM_CH, -16'sd500, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        frame(NUM_CH, 16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0, 3, 1'b0);
        frame(NUM_CH, -16'sd500, 16'sd0, 16'sh7FFF, 16'sd0, 3, 1'b0);
        frame(NUM_CH, 16'sd1234, -16'sd321, 16'sh4000, -16'sh2000, 2, 1'b0);
        drain("drain_c4");

        // Case 5a: sof reasserted on beat 5 -> abort, restart as channel 0
        base = n_ferr;
        frame(5, 16'sd7, 16'sd7, 16'sh7FFF, 16'sd0, 0, 1'b0);
        frame(NUM_CH, 16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        drain("drain_c5a");
        chk("ferr_restart", n_ferr - base, 1);
        // Case 5b: beats without sof in IDLE are dropped
        base = n_ferr;
        beat(1'b0, 16'sd999, 16'sd0, 16'sh7FFF, 16'sd0, 0, scyc);
        beat(1'b0, 16'sd999, 16'sd0, 16'sh7FFF, 16'sd0, 0, scyc);
        idle(3);
        chk("ferr_idle_drop", n_ferr - base, 2);
        // Case 5c: sof coincident with last channel closes the frame normally
        base = n_ferr;
        frame(NUM_CH, -16'sd500, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b1);
        frame(NUM_CH, 16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        drain("drain_c5c");
        chk("ferr_last_sof", n_ferr - base, 0);

        // Case 6: reset mid-frame and mid-pipeline
        frame(4, 16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        rst = 1'b1; #1;
        chk("rst_mid_frame_re", ifc.out_re, 0);
        idle(2);
        rst = 1'b0;
        idle(1);
        frame(NUM_CH, 16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        drain("drain_c6_pre");
        frame(NUM_CH, 16'sd300, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        idle(2);
        rst = 1'b1;
        q.delete();
        #1;
        chk("rst_pipe_out_re",    ifc.out_re,    0);
        chk("rst_pipe_out_im",    ifc.out_im,    0);
        chk("rst_pipe_out_valid", ifc.out_valid, 0);
        idle(3);
        rst = 1'b0;
        idle(10);
        frame(NUM_CH, 16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0, 0, 1'b0);
        drain("drain_c6");
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dbf_beam_combine.md
Name: dbf_beam_combine

Overview:
- Digital-beamforming combiner: the consumer of the per-channel complex weights (ph_real/ph_image) produced by the DBF weight generator.
- Accepts a time-multiplexed stream of NUM_CH channel I/Q samples, each paired with its weight.
- Per channel: complex multiply. Across the frame: coherent accumulation, then round, scale and saturate.
- Emits one complex beam sample per frame toward the downstream pulse-compression/detection chain.

Parameters:
- NUM_CH, 8, channels per frame (2..64).
- OUT_SHIFT, 15, right shift applied to the accumulator before saturation (1..24).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat qualifier for x_*/w_*/in_sof.
- in_sof  in  1  marks channel 0 of a frame; valid only with in_valid.
- x_re  in  16  channel sample real, signed two's complement.
- x_im  in  16  channel sample imag, signed.
- w_re  in  16  weight real, signed Q1.15.
- w_im  in  16  weight imag, signed Q1.15.
- out_valid  out  1  one-cycle pulse per completed frame.
- out_re  out  16  beam sample real, signed.
- out_im  out  16  beam sample imag, signed.
- sat  out  1  pulses with out_valid if either component saturated.
- frame_err  out  1  one-cycle pulse on framing violation.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, ch_cnt=0, accumulators 0, pipeline valids cleared. A partial frame in flight is discarded; no out_valid follows reset.
- States:
  - IDLE -> ACCUM on in_valid & in_sof. ch_cnt=1 after accepting channel 0.
  - ACCUM: each in_valid beat increments ch_cnt. The beat with ch_cnt=NUM_CH-1 closes the frame -> IDLE.
  - Cycles with in_valid=0 are bubbles; state and counters hold.
- Framing errors:
  - in_valid & in_sof while in ACCUM: frame_err=1 for one cycle, partial frame discarded, this beat starts a new frame as channel 0 (stay ACCUM, ch_cnt=1).
  - in_valid & !in_sof while in IDLE: beat dropped, frame_err=1.
  - When NUM_CH-1 is reached and an in_sof beat arrives in the same cycle, it is the last-channel case: the frame closes normally. An in_sof on the next beat is legal.
- Pipeline:
  - S1 registers inputs.
  - S2 forms four 32-bit signed products.
  - S3: p_re = xr*wr - xi*wi, p_im = xr*wi + xi*wr, each 33-bit signed.
  - S4 accumulator: the first beat of a frame loads p, later beats add. Width 33+clog2(NUM_CH); the accumulator never wraps.
  - S5 output register.
- Output arithmetic, per component:
  - y = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up).
  - Clamp to [-32768, 32767]; sat=1 if either component clamped.
- Latency and holding:
  - Last-channel beat sampled at edge n -> out_valid=1, with out_re/out_im/sat valid, for exactly the cycle after edge n+4.
  - out_re/out_im hold their value until the next out_valid.
  - sat and frame_err are pulses.
- Throughput: back-to-back frames at one beat per clock, no gap. The S4 load on the new first beat must not disturb the result of the frame in S5.
- No backpressure; the downstream side must accept every out_valid.

Test Plan:
1. NUM_CH=8, 8 beats x=1000+j0, w=0x7FFF+j0, sof on beat 0 -> out_re=8000, out_im=0, sat=0, out_valid exactly 4 cycles after the last beat.
2. x=0+j1000, w=0+j0x7FFF, 8 beats -> out_re=-8000, out_im=0. Then x=1000, w=j0x7FFF -> out_re=0, out_im=8000.
3. x=32767, w=0x7FFF, 8 beats -> out_re=32767, sat=1. Next frame x=-32768, w=0x7FFF -> out_re=-32768, sat=1.
4. Two frames back-to-back with no gap (frame A as case 1, frame B x=-500, w=0x7FFF) -> out_valid on consecutive frame boundaries, out_re=8000 then -4000; random in_valid bubbles inserted give the same results.
5. sof reasserted at beat 5 of a frame -> frame_err pulse, no output for the aborted frame, following 8-beat frame result correct. Beats without sof in IDLE -> dropped, frame_err pulse each.
6. rst asserted mid-frame (beat 4) and mid-pipeline -> outputs 0 immediately, no out_valid. After release, a clean frame per case 1 yields 8000.
